// File: rtl/mk14_pkg.sv
// Shared MK14 SoC types: program loader state and error encodings.
package mk14_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ADDR_HI = 3'd1,
        ADDR_LO = 3'd2,
        LEN     = 3'd3,
        DATA    = 3'd4,
        CSUM    = 3'd5,
        DRAIN   = 3'd6
    } loader_state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_CSUM    = 2'd1,
        ERR_OVERRUN = 2'd2,
        ERR_TIMEOUT = 2'd3
    } loader_err_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;

endpackage

// File: rtl/mk14_rx_loader.sv
// Serial program loader: parses SYNC/ADDR/LEN/DATA/CSUM records from the UART,
// borrows the RAM bus from the CPU via hold_req/hold_ack, writes the payload
// through a one-entry pending buffer and reports the outcome of each frame.
module mk14_rx_loader
    import mk14_pkg::*;
#(
    parameter int         CLOCK_FREQ_MHZ = 50,
    parameter int         TIMEOUT_MS     = 20,
    parameter int         ADDR_W         = 16,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              hold_req,
    input  logic              hold_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              rx_wait,
    output logic              go,
    output logic [ADDR_W-1:0] go_addr,
    output logic              frame_ok,
    output logic              frame_err,
    output logic [1:0]        err_code
);

    localparam int TIMEOUT_CYCLES = CLOCK_FREQ_MHZ * 1000 * TIMEOUT_MS;
    localparam int TO_W           = $clog2(TIMEOUT_CYCLES + 1);
    // Timeout fires on the last idle cycle of the window, so the frame is
    // abandoned after exactly TIMEOUT_CYCLES cycles without a byte.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    loader_state_t     state_reg, state_next;
    loader_err_t       err_code_reg, err_code_next;
    logic              hold_req_reg, hold_req_next;
    logic [7:0]        addr_hi_reg, addr_hi_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        len_reg, len_next;
    logic              exec_reg, exec_next;
    logic [7:0]        sum_reg, sum_next;
    logic              csum_ok_reg, csum_ok_next;
    logic              pend_valid_reg, pend_valid_next;
    logic [ADDR_W-1:0] pend_addr_reg, pend_addr_next;
    logic [7:0]        pend_data_reg, pend_data_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              go_reg, go_next;
    logic [ADDR_W-1:0] go_addr_reg, go_addr_next;
    logic              frame_ok_reg, frame_ok_next;
    logic              frame_err_reg, frame_err_next;

    logic              write_issue;
    logic              counting;
    logic              timeout_hit;
    logic              overrun;
    logic [7:0]        sum_with_byte;
    logic              abort;
    loader_err_t       abort_code;

    // The buffered byte goes out whenever the CPU has granted the bus; the
    // write is suppressed during reset so nothing escapes in the rst cycle.
    assign write_issue   = pend_valid_reg && hold_ack;
    assign mem_we        = write_issue && !rst;
    assign mem_addr      = mem_we ? pend_addr_reg : '0;
    assign mem_wdata     = mem_we ? pend_data_reg : '0;

    assign counting      = (state_reg != IDLE) && (state_reg != DRAIN);
    assign timeout_hit   = counting && !rx_valid && (to_cnt_reg == TO_LAST);
    // A new byte may only enter the buffer if it is empty or emptying now.
    assign overrun       = rx_valid && pend_valid_reg && !write_issue;
    assign sum_with_byte = sum_reg + rx_data;

    assign hold_req      = hold_req_reg;
    assign rx_wait       = (state_reg != IDLE);
    assign go            = go_reg;
    assign go_addr       = go_addr_reg;
    assign frame_ok      = frame_ok_reg;
    assign frame_err     = frame_err_reg;
    assign err_code      = err_code_reg;

    // State register and datapath registers; synchronous reset to all zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            err_code_reg   <= ERR_NONE;
            hold_req_reg   <= 1'b0;
            addr_hi_reg    <= '0;
            addr_reg       <= '0;
            len_reg        <= '0;
            exec_reg       <= 1'b0;
            sum_reg        <= '0;
            csum_ok_reg    <= 1'b0;
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= '0;
            pend_data_reg  <= '0;
            to_cnt_reg     <= '0;
            go_reg         <= 1'b0;
            go_addr_reg    <= '0;
            frame_ok_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            err_code_reg   <= err_code_next;
            hold_req_reg   <= hold_req_next;
            addr_hi_reg    <= addr_hi_next;
            addr_reg       <= addr_next;
            len_reg        <= len_next;
            exec_reg       <= exec_next;
            sum_reg        <= sum_next;
            csum_ok_reg    <= csum_ok_next;
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
            pend_data_reg  <= pend_data_next;
            to_cnt_reg     <= to_cnt_next;
            go_reg         <= go_next;
            go_addr_reg    <= go_addr_next;
            frame_ok_reg   <= frame_ok_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    // Frame parser, pending-buffer control, timeout and outcome reporting.
    always_comb begin
        state_next      = state_reg;
        err_code_next   = err_code_reg;
        hold_req_next   = hold_req_reg;
        addr_hi_next    = addr_hi_reg;
        addr_next       = addr_reg;
        len_next        = len_reg;
        exec_next       = exec_reg;
        sum_next        = sum_reg;
        csum_ok_next    = csum_ok_reg;
        pend_valid_next = pend_valid_reg && !write_issue;
        pend_addr_next  = pend_addr_reg;
        pend_data_next  = pend_data_reg;
        to_cnt_next     = (!counting || rx_valid) ? '0 : to_cnt_reg + 1'b1;
        go_next         = 1'b0;
        go_addr_next    = go_addr_reg;
        frame_ok_next   = 1'b0;
        frame_err_next  = 1'b0;
        abort           = 1'b0;
        abort_code      = ERR_NONE;

        case (state_reg)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    hold_req_next = 1'b1;
                    sum_next      = '0;
                    state_next    = ADDR_HI;
                end
            end
            ADDR_HI: begin
                if (rx_valid) begin
                    addr_hi_next = rx_data;
                    sum_next     = sum_with_byte;
                    state_next   = ADDR_LO;
                end
            end
            ADDR_LO: begin
                if (rx_valid) begin
                    addr_next  = ADDR_W'({addr_hi_reg, rx_data});
                    sum_next   = sum_with_byte;
                    state_next = LEN;
                end
            end
            LEN: begin
                if (rx_valid) begin
                    len_next   = rx_data;
                    exec_next  = (rx_data == 8'h00);
                    sum_next   = sum_with_byte;
                    state_next = (rx_data == 8'h00) ? CSUM : DATA;
                end
            end
            DATA: begin
                if (overrun) begin
                    abort      = 1'b1;
                    abort_code = ERR_OVERRUN;
                end else if (rx_valid) begin
                    pend_valid_next = 1'b1;
                    pend_addr_next  = addr_reg;
                    pend_data_next  = rx_data;
                    addr_next       = addr_reg + 1'b1;
                    len_next        = len_reg - 1'b1;
                    sum_next        = sum_with_byte;
                    if (len_reg == 8'd1) begin
                        state_next = CSUM;
                    end
                end
            end
            CSUM: begin
                if (overrun) begin
                    abort      = 1'b1;
                    abort_code = ERR_OVERRUN;
                end else if (rx_valid) begin
                    csum_ok_next = (sum_with_byte == 8'h00);
                    state_next   = DRAIN;
                end
            end
            DRAIN: begin
                // Release the bus only once the last payload byte is out.
                if (!pend_valid_reg) begin
                    hold_req_next = 1'b0;
                    state_next    = IDLE;
                    if (csum_ok_reg) begin
                        frame_ok_next = 1'b1;
                        err_code_next = ERR_NONE;
                        if (exec_reg) begin
                            go_next      = 1'b1;
                            go_addr_next = addr_reg;
                        end
                    end else begin
                        frame_err_next = 1'b1;
                        err_code_next  = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout_hit) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
        end

        // Any error abandons the frame: drop the buffered write, free the bus.
        if (abort) begin
            state_next      = IDLE;
            hold_req_next   = 1'b0;
            pend_valid_next = 1'b0;
            frame_err_next  = 1'b1;
            err_code_next   = abort_code;
        end
    end

endmodule
